// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and the instruction RAM:
// geometry and the loader state encodings.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH          = 32;
  localparam int unsigned IMEM_ADDR_W         = 5;
  localparam int unsigned IMEM_BYTES_PER_WORD = 4;

  localparam logic [2:0] IMEM_LD_IDLE  = 3'd0;
  localparam logic [2:0] IMEM_LD_RECV  = 3'd1;
  localparam logic [2:0] IMEM_LD_WRITE = 3'd2;
  localparam logic [2:0] IMEM_LD_CSUM  = 3'd3;
  localparam logic [2:0] IMEM_LD_DONE  = 3'd4;

endpackage

// File: rtl/imem_word_asm.sv
// Big-endian 8-to-32 word assembler: shifts accepted bytes in from the right
// and counts them; word_ready_o is high once a full word has been collected.
module imem_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [2:0]  byte_cnt_o,
  output logic        word_ready_o
);

  localparam logic [2:0] FullCnt = 3'(IMEM_BYTES_PER_WORD);

  logic [31:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (byte_en_i && (cnt_q < FullCnt)) begin
      sr_d  = {sr_q[23:0], byte_i};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o       = sr_q;
  assign byte_cnt_o   = cnt_q;
  assign word_ready_o = (cnt_q == FullCnt);

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM loader: assembles a big-endian byte stream into words, writes them
// and holds the CPU in reset meanwhile. Optional trailing checksum: IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Load_Start,
  input  logic [ADDR_W:0]   Load_Len,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              Wr_En,
  output logic [31:0]       Wr_Addr,
  output logic [31:0]       Wr_Data,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Load_Done,
  output logic              Load_Err
);

  localparam int unsigned LenW   = ADDR_W + 1;
  localparam logic [ADDR_W:0] MaxLen = LenW'(DEPTH);
  localparam logic [2:0] LastWordBytes = 3'(IMEM_BYTES_PER_WORD - 1);

`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] AfterLast = IMEM_LD_CSUM;
`else
  localparam logic [2:0] AfterLast = IMEM_LD_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic        asm_clear, asm_en, asm_ready;
  logic [31:0] asm_word;
  logic [2:0]  asm_cnt;
  logic [31:0] cur_addr;
  logic        last_word;
  logic        byte_fire;

  imem_word_asm u_word_asm (
    .clk_i        (Clk),
    .rst_ni       (Resetn),
    .clear_i      (asm_clear),
    .byte_en_i    (asm_en),
    .byte_i       (Byte_In),
    .word_o       (asm_word),
    .byte_cnt_o   (asm_cnt),
    .word_ready_o (asm_ready)
  );

  assign byte_fire = Byte_Valid && Byte_Ready;
  assign asm_en    = byte_fire && (state_q == IMEM_LD_RECV);
  // A fresh load or a completed write both start the next word from empty.
  assign asm_clear = ((state_q == IMEM_LD_IDLE) && Load_Start) || (state_q == IMEM_LD_WRITE);
  assign cur_addr  = BASE_ADDR + {{(30 - ADDR_W){1'b0}}, idx_q, 2'b00};
  assign last_word = (({1'b0, idx_q} + LenW'(1)) == len_q);

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CSUM_EN
    xor_d     = xor_q;
    err_d     = err_q;
`endif
    case (state_q)
      IMEM_LD_IDLE: begin
        if (Load_Start) begin
          len_d   = (Load_Len > MaxLen) ? MaxLen : Load_Len;
          idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
          xor_d   = '0;
          err_d   = 1'b0;
`endif
          state_d = (len_d == '0) ? AfterLast : IMEM_LD_RECV;
        end
      end
      IMEM_LD_RECV: begin
        if (asm_en) begin
`ifdef IMEM_LOADER_CSUM_EN
          xor_d = xor_q ^ Byte_In;
`endif
          if (asm_cnt == LastWordBytes) state_d = IMEM_LD_WRITE;
        end
      end
      IMEM_LD_WRITE: begin
        wr_addr_d = cur_addr;
        wr_data_d = asm_word;
        idx_d     = idx_q + 1'b1;
        state_d   = last_word ? AfterLast : IMEM_LD_RECV;
      end
`ifdef IMEM_LOADER_CSUM_EN
      IMEM_LD_CSUM: begin
        if (byte_fire) begin
          err_d   = (Byte_In != xor_q);
          state_d = IMEM_LD_DONE;
        end
      end
`endif
      IMEM_LD_DONE: state_d = IMEM_LD_IDLE;
      default:      state_d = IMEM_LD_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q   <= IMEM_LD_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      err_q <= err_d;
    end
  end

  assign Byte_Ready = (state_q == IMEM_LD_RECV) || (state_q == IMEM_LD_CSUM);
  assign Load_Err   = err_q;
`else
  assign Byte_Ready = (state_q == IMEM_LD_RECV);
  assign Load_Err   = 1'b0;
`endif

  // The write port shows the live word during WRITE and holds it afterwards.
  assign Wr_En     = (state_q == IMEM_LD_WRITE) && asm_ready;
  assign Wr_Addr   = Wr_En ? cur_addr : wr_addr_q;
  assign Wr_Data   = Wr_En ? asm_word : wr_data_q;
  assign Busy      = (state_q != IMEM_LD_IDLE);
  assign Cpu_Hold  = Busy;
  assign Load_Done = (state_q == IMEM_LD_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares every Wr_En pulse.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        Load_Start = 1'b0;
  logic [5:0]  Load_Len = '0;
  logic [7:0]  Byte_In = '0;
  logic        Byte_Valid = 1'b0;
  logic        Byte_Ready, Wr_En, Cpu_Hold, Busy, Load_Done, Load_Err;
  logic [31:0] Wr_Addr, Wr_Data;

  always #5 Clk = ~Clk;

  imem_loader dut (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .Load_Start (Load_Start),
    .Load_Len   (Load_Len),
    .Byte_In    (Byte_In),
    .Byte_Valid (Byte_Valid),
    .Byte_Ready (Byte_Ready),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Cpu_Hold   (Cpu_Hold),
    .Busy       (Busy),
    .Load_Done  (Load_Done),
    .Load_Err   (Load_Err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [7:0]  tb_xor = '0;
  int          byte_pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Load_Done) done_cnt++;
    if (Wr_En) begin
      wr_cnt++;
      last_addr = Wr_Addr;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got write %h at %h, expected no write", Wr_Data, Wr_Addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", Wr_Addr, mon_e.addr);
        check("wr_data", Wr_Data, mon_e.data);
      end
    end
  end

  task automatic expect_wr(input int idx, input logic [31:0] w);
    wr_t e;
    e.addr = 32'(idx) << 2;
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_ready"}, Byte_Ready, 0);
    check({tag, "_wr_en"}, Wr_En, 0);
    check({tag, "_cpu_hold"}, Cpu_Hold, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_load_done"}, Load_Done, 0);
    check({tag, "_load_err"}, Load_Err, 0);
    check({tag, "_wr_addr"}, Wr_Addr, 0);
    check({tag, "_wr_data"}, Wr_Data, 0);
  endtask

  // Returns at the negedge of the first cycle after Load_Start was sampled.
  task automatic start_load(input int len);
    @(negedge Clk);
    Load_Start = 1'b1;
    Load_Len   = 6'(len);
    tb_xor     = '0;
    byte_pos   = 0;
    @(negedge Clk);
    Load_Start = 1'b0;
  endtask

  // Returns at the negedge just before the edge that accepts the byte.
  task automatic send_raw(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge Clk);
      Byte_Valid = 1'b0;
    end
    @(negedge Clk);
    Byte_In    = b;
    Byte_Valid = 1'b1;
    n = 0;
    while (!Byte_Ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("byte_ready_seen", Byte_Ready, 1);
  endtask

  task automatic send_data(input logic [7:0] b, input int gap);
    send_raw(b, gap);
    tb_xor = tb_xor ^ b;
    byte_pos++;
    if (byte_pos % 4 == 0) begin
      @(negedge Clk);
      Byte_Valid = 1'b0;
      check("wr_en_latency", Wr_En, 1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_data(w[8*i +: 8], gap);
  endtask

  task automatic finish_csum();
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] c;
    c = tb_xor;
    send_raw(c, 0);
    @(negedge Clk);
    Byte_Valid = 1'b0;
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!Load_Done && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check("load_done", Load_Done, 1);
    @(negedge Clk);
    check("hold_released", Cpu_Hold, 0);
    check("busy_released", Busy, 0);
  endtask

  task automatic run_stream(input int gap);
    done_cnt = 0;
    expect_wr(0, 32'h3C01_1111);
    expect_wr(1, 32'h3C02_1111);
    expect_wr(2, 32'h0022_1820);
    start_load(3);
    check("hold_after_start", Cpu_Hold, 1);
    check("busy_after_start", Busy, 1);
    send_word(32'h3C01_1111, gap);
    send_word(32'h3C02_1111, gap);
    send_word(32'h0022_1820, gap);
    finish_csum();
    wait_done();
    check("done_once", 32'(done_cnt), 1);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int wc;
    logic [31:0] w;
    repeat (3) @(negedge Clk);
    check_zero("reset");
    Resetn = 1'b1;

    run_stream(0);
    run_stream(3);

    // Zero-length load: no writes, immediate completion.
    done_cnt = 0;
    wc = wr_cnt;
    start_load(0);
`ifdef IMEM_LOADER_CSUM_EN
    check("len0_csum_ready", Byte_Ready, 1);
`else
    check("len0_done_timing", Load_Done, 1);
    check("len0_byte_ready", Byte_Ready, 0);
`endif
    finish_csum();
    wait_done();
    check("len0_done_once", 32'(done_cnt), 1);
    check("len0_no_write", 32'(wr_cnt - wc), 0);

    // Oversized request is clamped to the RAM depth.
    done_cnt = 0;
    start_load(40);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'hA5 ^ 8'(i), 8'h3C, ~8'(i)};
      expect_wr(i, w);
      send_word(w, 0);
    end
    finish_csum();
    wait_done();
    check("clamp_last_addr", last_addr, 32'h0000_007C);
    check("clamp_done_once", 32'(done_cnt), 1);
    wc = wr_cnt;
    @(negedge Clk);
    Byte_In    = 8'h11;
    Byte_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("clamp_no_accept", Byte_Ready, 0);
    end
    Byte_Valid = 1'b0;
    check("clamp_no_extra_write", 32'(wr_cnt - wc), 0);
    check("queue_drained_clamp", 32'(exp_q.size()), 0);

    // Reset in the middle of the second word.
    expect_wr(0, 32'h3C01_1111);
    start_load(2);
    send_word(32'h3C01_1111, 0);
    send_data(8'h3C, 0);
    send_data(8'h02, 0);
    @(negedge Clk);
    Byte_Valid = 1'b0;
    Resetn     = 1'b0;
    @(negedge Clk);
    check_zero("midload_reset");
    Resetn = 1'b1;
    done_cnt = 0;
    expect_wr(0, 32'h0800_0019);
    start_load(1);
    send_word(32'h0800_0019, 0);
    finish_csum();
    wait_done();
    check("reload_done_once", 32'(done_cnt), 1);
    check("queue_drained_reload", 32'(exp_q.size()), 0);

`ifdef IMEM_LOADER_CSUM_EN
    expect_wr(0, 32'h0080_0008);
    start_load(1);
    send_word(32'h0080_0008, 0);
    send_raw(8'h88, 0);
    @(negedge Clk);
    Byte_Valid = 1'b0;
    wait_done();
    check("csum_good_err", Load_Err, 0);

    expect_wr(0, 32'h0080_0008);
    start_load(1);
    send_word(32'h0080_0008, 0);
    send_raw(8'h89, 0);
    @(negedge Clk);
    Byte_Valid = 1'b0;
    wait_done();
    check("csum_bad_err", Load_Err, 1);
    repeat (3) @(negedge Clk);
    check("csum_err_held", Load_Err, 1);
    expect_wr(0, 32'h0080_0008);
    start_load(1);
    check("csum_err_cleared", Load_Err, 0);
    send_word(32'h0080_0008, 0);
    finish_csum();
    wait_done();
    check("csum_reload_err", Load_Err, 0);
`endif

    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
